// File: rtl/serial_fa_adder.sv
// Bit-serial WIDTH-bit adder feeding one udp_fa full-adder cell, LSB first.
// Optional subtract mode (adds port sub) is enabled by defining SERIAL_FA_SUB_EN.

module udp_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_fa_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_FA_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    count_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;
  logic             fa_sum_s;
  logic             fa_carry_s;

  // Operand B and initial carry as latched on an accepting edge.
  always_comb begin
    b_load_s = b;
    c_load_s = cin;
`ifdef SERIAL_FA_SUB_EN
    if (sub) begin
      b_load_s = ~b;
      c_load_s = 1'b1;
    end else begin
      b_load_s = b;
      c_load_s = cin;
    end
`endif
  end

  udp_fa u_fa (
    .a  (opa_r[0]),
    .b  (opb_r[0]),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_carry_s)
  );

  // Sequencer: accept operands, shift one bit pair per cycle, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      opa_r   <= '0;
      opb_r   <= '0;
      acc_r   <= '0;
      count_r <= '0;
      carry_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            opa_r   <= a;
            opb_r   <= b_load_s;
            carry_r <= c_load_s;
            count_r <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          carry_r <= fa_carry_s;
          acc_r   <= {fa_sum_s, acc_r[WIDTH-1:1]};
          opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
          opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
          count_r <= count_r + CW'(1);
          // Last bit pair: the shifted-in word is the finished result.
          if (count_r == LAST) begin
            sum_r   <= {fa_sum_s, acc_r[WIDTH-1:1]};
            cout_r  <= fa_carry_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Randomised self-checking bench for serial_fa_adder against a cycle-count/arithmetic model.
// Subtract checks are compiled in when SERIAL_FA_SUB_EN is defined.

module tb_serial_fa_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_FA_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  serial_fa_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_FA_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full-width arithmetic result of an accepted operation.
  function automatic logic [W:0] calc();
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef SERIAL_FA_SUB_EN
    if (sub) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`endif
    return r;
  endfunction

  // Model: an accepted op occupies W cycles, then publishes a+b+cin with a done pulse.
  int         m_left = 0;
  logic [W:0] m_res = '0;
  logic [W-1:0] m_sum = '0;
  logic       m_cout = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= '0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 1) begin
        m_sum  <= m_res[W-1:0];
        m_cout <= m_res[W];
        m_done <= 1'b1;
        m_left <= 0;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_res  <= calc();
        m_left <= W;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("sum",  {24'd0, sum},  {24'd0, m_sum});
      chk("cout", {31'd0, cout}, {31'd0, m_cout});
    end
  end

  // Launch one op, then wait (bounded) for done; pins cycle count and literal result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) break;
    end
    chk({nm, "_latency"}, n, W + 1);
    chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
    @(negedge clk);
    chk({nm, "_hold"}, {24'd0, sum}, {24'd0, es});
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;

    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "add3c05");
    run_op(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, "addff01c");
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ripple");

    // Back-to-back with start held high; RUN-time input changes must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) begin a = 8'hEE; b = 8'h77; end
      if (n == 4) begin a = 8'h10; b = 8'h20; end
      if (done) break;
    end
    chk("b2b1_latency", n, W + 1);
    chk("b2b1_sum", {24'd0, sum}, 32'h30);
    chk("b2b1_cout", {31'd0, cout}, 32'd0);
    a = 8'h80; b = 8'h80;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) start = 1'b0;
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      if (done) break;
    end
    chk("b2b2_latency", n, W + 1);
    chk("b2b2_sum", {24'd0, sum}, 32'h00);
    chk("b2b2_cout", {31'd0, cout}, 32'd1);
    start = 1'b0;
    @(negedge clk);

    // Abort mid-run with reset asserted between clock edges.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "preabort");
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sum",  {24'd0, sum},  32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_nodone", n, 0);
    rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "postabort");

`ifdef SERIAL_FA_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub1001");
    run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, "sub0102");
    sub = 1'b0;
`endif

    // Random traffic: model comparison runs every cycle.
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_FA_SUB_EN
      sub = 1'($urandom);
`endif
      if (done) n++;
    end
    start = 1'b0;
    chk("random_ops_seen", {31'd0, n > 100}, 32'd1);
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
